// File: rtl/user_cnn_pkg.sv
// user_cnn_pkg: shared definitions for the UserCnn int8 MAC engine.
//   Holds the register map (offsets relative to the window base 0x1000 of the
//   low 17 address bits), STATUS bit positions, the FSM state type and the OBI
//   request/response structs used on the user bus.
package user_cnn_pkg;

  // Width of the OBI transaction id carried through aid/rid.
  localparam int unsigned IdWidth = 4;

  // Width of the LEN register (supports up to 1024 words plus an out-of-range value).
  localparam int unsigned LenWidth = 11;

  // The engine window starts at 0x1000 within the 17-bit decoded address space.
  localparam logic [16:0] WindowBase = 17'h0_1000;

  // Register and buffer offsets relative to WindowBase.
  localparam logic [16:0] CtrlOffset   = 17'h0_0000;
  localparam logic [16:0] StatusOffset = 17'h0_0004;
  localparam logic [16:0] LenOffset    = 17'h0_0008;
  localparam logic [16:0] ResultOffset = 17'h0_000C;
  localparam logic [16:0] WbufOffset   = 17'h0_1000;
  localparam logic [16:0] FbufOffset   = 17'h0_2000;

  // STATUS register bit positions.
  localparam int unsigned StatusBusyBit   = 0;
  localparam int unsigned StatusDoneBit   = 1;
  localparam int unsigned StatusLenerrBit = 2;

  // CTRL register bit positions.
  localparam int unsigned CtrlStartBit = 0;

  typedef enum logic [0:0] {
    Idle = 1'b0,
    Run  = 1'b1
  } cnn_state_e;

  typedef struct packed {
    logic               req;
    logic               we;
    logic [3:0]         be;
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic [IdWidth-1:0] aid;
  } cnn_obi_req_t;

  typedef struct packed {
    logic               gnt;
    logic               rvalid;
    logic [31:0]        rdata;
    logic               err;
    logic [IdWidth-1:0] rid;
  } cnn_obi_rsp_t;

  // Sign-extend an 18-bit dot product into the 32-bit accumulator domain.
  function automatic logic [31:0] sext18(input logic signed [17:0] v);
    return {{14{v[17]}}, v};
  endfunction

endpackage

// File: rtl/user_cnn_mac_engine_dot4.sv
// user_cnn_dot4: combinational 4-lane signed int8 dot product.
//   Ports: a_i / b_i carry four packed int8 lanes each (lane i = bits [8i+7:8i]);
//   dot_o is the signed sum of the four lane products, 18 bits wide.
module user_cnn_dot4 (
  input  logic        [31:0] a_i,
  input  logic        [31:0] b_i,
  output logic signed [17:0] dot_o
);

  logic signed [15:0] prod;

  // Each int8*int8 product fits in 16 signed bits (range -16256..16384);
  // four of them need 18 bits to hold +65536 without overflow.
  always_comb begin
    dot_o = '0;
    prod  = '0;
    for (int i = 0; i < 4; i++) begin
      prod  = 16'($signed(a_i[8*i +: 8])) * 16'($signed(b_i[8*i +: 8]));
      dot_o = dot_o + 18'(prod);
    end
  end

endmodule

// File: rtl/user_cnn_mac_engine.sv
// user_cnn_mac_engine: OBI subordinate with weight/feature buffers and a
//   sequential int8 dot-product engine (one packed word per cycle).
//   Ports: clk_i/rst_i (async, active-high), obi_req_i/obi_rsp_o (OBI user bus,
//   gnt=req, response one cycle later), irq_o (level, mirrors STATUS.done).
module user_cnn_mac_engine
  import user_cnn_pkg::*;
#(
  parameter int unsigned Depth     = 256,
  parameter type         obi_req_t = cnn_obi_req_t,
  parameter type         obi_rsp_t = cnn_obi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output logic     irq_o
);

  // Buffer storage is rounded up to a power of two so the word index width
  // matches the array exactly; only the first Depth words are reachable.
  localparam int unsigned IdxW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned MemWords = 1 << IdxW;
  localparam logic [LenWidth-1:0] DepthW = LenWidth'(Depth);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  cnn_state_e          state_q, state_d;
  logic [LenWidth-1:0] idx_q, idx_d;
  logic [LenWidth-1:0] len_q, len_d;
  logic [LenWidth-1:0] run_len_q, run_len_d;
  logic [31:0]         acc_q, acc_d;
  logic [31:0]         result_q, result_d;
  logic                done_q, done_d;
  logic                lenerr_q, lenerr_d;

  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [IdWidth-1:0]  rid_q, rid_d;

  logic [31:0] wbuf_mem [MemWords];
  logic [31:0] fbuf_mem [MemWords];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [16:0]     offset;
  logic [IdxW-1:0] bus_idx;
  logic            is_ctrl, is_status, is_len, is_result, is_wbuf, is_fbuf;
  logic            in_buf_range, mapped, busy;
  logic            fire, wr_ok;
  logic            start_wr, status_wr, len_wr, wbuf_wr, fbuf_wr;
  logic [31:0]     status_word;
  logic            unused_addr;

  assign busy        = (state_q == Run);
  assign fire        = obi_req_i.req;
  assign unused_addr = ^obi_req_i.addr[31:17];

  always_comb begin
    // Addresses below the window base wrap to large offsets and decode as unmapped.
    offset       = obi_req_i.addr[16:0] - WindowBase;
    bus_idx      = offset[IdxW+1:2];
    in_buf_range = (offset[1:0] == 2'b00) && ({1'b0, offset[11:2]} < DepthW);
    is_ctrl      = (offset == CtrlOffset);
    is_status    = (offset == StatusOffset);
    is_len       = (offset == LenOffset);
    is_result    = (offset == ResultOffset);
    is_wbuf      = (offset[16:12] == WbufOffset[16:12]) && in_buf_range;
    is_fbuf      = (offset[16:12] == FbufOffset[16:12]) && in_buf_range;
    mapped       = is_ctrl | is_status | is_len | is_result | is_wbuf | is_fbuf;
  end

  // Error responses carry no side effect, so every write strobe is gated by wr_ok.
  always_comb begin
    err_d = fire & (~mapped
                    | (obi_req_i.we & is_result)
                    | (obi_req_i.we & (is_wbuf | is_fbuf) & busy));
    wr_ok     = fire & obi_req_i.we & ~err_d;
    start_wr  = wr_ok & is_ctrl & obi_req_i.wdata[CtrlStartBit];
    status_wr = wr_ok & is_status;
    len_wr    = wr_ok & is_len;
    wbuf_wr   = wr_ok & is_wbuf;
    fbuf_wr   = wr_ok & is_fbuf;
  end

  // ---------------------------------------------------------------------------
  // Read data / response
  // ---------------------------------------------------------------------------
  always_comb begin
    status_word                  = '0;
    status_word[StatusBusyBit]   = busy;
    status_word[StatusDoneBit]   = done_q;
    status_word[StatusLenerrBit] = lenerr_q;
  end

  always_comb begin
    rvalid_d = fire;
    rid_d    = fire ? obi_req_i.aid : '0;
    rdata_d  = '0;
    // Writes, CTRL reads and error responses all return zero.
    if (fire && !obi_req_i.we && !err_d) begin
      if (is_status)      rdata_d = status_word;
      else if (is_len)    rdata_d = 32'(len_q);
      else if (is_result) rdata_d = result_q;
      else if (is_wbuf)   rdata_d = wbuf_mem[bus_idx];
      else if (is_fbuf)   rdata_d = fbuf_mem[bus_idx];
      else                rdata_d = '0;
    end
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = obi_req_i.req;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.err    = err_q;
    obi_rsp_o.rid    = rid_q;
  end

  assign irq_o = done_q;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic        [31:0] run_w, run_f;
  logic signed [17:0] dot;
  logic        [31:0] acc_next;

  assign run_w    = wbuf_mem[idx_q[IdxW-1:0]];
  assign run_f    = fbuf_mem[idx_q[IdxW-1:0]];
  assign acc_next = acc_q + sext18(dot);

  user_cnn_dot4 u_dot4 (
    .a_i   (run_w),
    .b_i   (run_f),
    .dot_o (dot)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    result_d  = result_q;
    len_d     = len_q;
    run_len_d = run_len_q;
    done_d    = done_q;
    lenerr_d  = lenerr_q;

    // LEN may change at any time; a run in progress keeps its own copy.
    if (len_wr) len_d = obi_req_i.wdata[LenWidth-1:0];

    if (status_wr) begin
      if (obi_req_i.wdata[StatusDoneBit])   done_d   = 1'b0;
      if (obi_req_i.wdata[StatusLenerrBit]) lenerr_d = 1'b0;
    end

    unique case (state_q)
      Idle: begin
        if (start_wr) begin
          if ((len_q != '0) && (len_q <= DepthW)) begin
            state_d   = Run;
            idx_d     = '0;
            acc_d     = '0;
            run_len_d = len_q;
            done_d    = 1'b0;
          end else begin
            lenerr_d = 1'b1;
          end
        end
      end
      Run: begin
        // Starts arriving here are ignored without an error response.
        acc_d = acc_next;
        idx_d = idx_q + 1'b1;
        if (idx_q == run_len_q - 1'b1) begin
          result_d = acc_next;
          done_d   = 1'b1; // end of run wins over a same-cycle W1C
          state_d  = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= Idle;
      idx_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      len_q     <= '0;
      run_len_q <= '0;
      done_q    <= 1'b0;
      lenerr_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      len_q     <= len_d;
      run_len_q <= run_len_d;
      done_q    <= done_d;
      lenerr_q  <= lenerr_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rid_q     <= rid_d;
    end
  end

  // Operand buffers: no reset, byte-enable writes.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (wbuf_wr && obi_req_i.be[b]) wbuf_mem[bus_idx][8*b +: 8] <= obi_req_i.wdata[8*b +: 8];
      if (fbuf_wr && obi_req_i.be[b]) fbuf_mem[bus_idx][8*b +: 8] <= obi_req_i.wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_user_cnn_mac_engine.sv
module tb_user_cnn_mac_engine;
  import user_cnn_pkg::*;

  localparam int unsigned DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h2000_1000;
  localparam logic [31:0] O_CTRL = 32'h000, O_STAT = 32'h004, O_LEN = 32'h008, O_RES = 32'h00C;
  localparam logic [31:0] O_WBUF = 32'h1000, O_FBUF = 32'h2000;

  logic         clk = 1'b0;
  logic         rst;
  cnn_obi_req_t obi_req;
  cnn_obi_rsp_t obi_rsp;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wmod [DEPTH];
  logic [31:0] fmod [DEPTH];

  always #5 clk = ~clk;

  user_cnn_mac_engine #(.Depth(DEPTH)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .obi_req_i (obi_req),
    .obi_rsp_o (obi_rsp),
    .irq_o     (irq)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference dot product: plain integer arithmetic over the model buffers.
  function automatic logic [31:0] model_dot(input int len);
    bit [31:0] acc;
    int a, b;
    acc = 0;
    for (int i = 0; i < len; i++)
      for (int l = 0; l < 4; l++) begin
        a   = $signed(wmod[i][8*l +: 8]);
        b   = $signed(fmod[i][8*l +: 8]);
        acc = acc + 32'(a * b);
      end
    return acc;
  endfunction

  // One OBI access; checks the grant, the one-cycle response and the id echo.
  task automatic bus(input logic we, input logic [31:0] off, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rdata, output logic err);
    logic [IdWidth-1:0] aid;
    aid = IdWidth'($urandom_range(0, 15));
    @(negedge clk);
    obi_req.req = 1'b1; obi_req.we = we; obi_req.addr = BASE + off;
    obi_req.wdata = wdata; obi_req.be = be; obi_req.aid = aid;
    #1 check_eq("gnt", 32'(obi_rsp.gnt), 32'd1);
    @(posedge clk); #1;
    obi_req.req = 1'b0;
    check_eq("rvalid", 32'(obi_rsp.rvalid), 32'd1);
    check_eq("rid", 32'(obi_rsp.rid), 32'(aid));
    rdata = obi_rsp.rdata;
    err   = obi_rsp.err;
  endtask

  task automatic wr(input string tag, input logic [31:0] off, input logic [31:0] d,
                    input logic [3:0] be, input logic exp_err);
    logic [31:0] r; logic e;
    bus(1'b1, off, d, be, r, e);
    check_eq({tag, "_err"}, 32'(e), 32'(exp_err));
  endtask

  task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp_d,
                    input logic exp_err);
    logic [31:0] r; logic e;
    bus(1'b0, off, 32'h0, 4'hF, r, e);
    check_eq({tag, "_err"}, 32'(e), 32'(exp_err));
    check_eq({tag, "_data"}, r, exp_d);
  endtask

  task automatic load_w(input int i, input logic [31:0] d);
    wr("wbuf_wr", O_WBUF + 32'(4 * i), d, 4'hF, 1'b0);
    wmod[i] = d;
  endtask

  task automatic load_f(input int i, input logic [31:0] d);
    wr("fbuf_wr", O_FBUF + 32'(4 * i), d, 4'hF, 1'b0);
    fmod[i] = d;
  endtask

  // Write start, then stream STATUS reads every cycle and count busy responses.
  task automatic start_and_count(input string tag, input int exp_busy);
    int busy_n;
    wr({tag, "_start"}, O_CTRL, 32'h1, 4'hF, 1'b0);
    busy_n = 0;
    @(negedge clk);
    obi_req.req = 1'b1; obi_req.we = 1'b0; obi_req.addr = BASE + O_STAT; obi_req.aid = '0;
    for (int k = 0; k < exp_busy + 4; k++) begin
      @(posedge clk); #1;
      if (obi_rsp.rdata[StatusBusyBit]) busy_n++;
    end
    obi_req.req = 1'b0;
    check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] r; logic e;
    int n;
    n = 0;
    do begin
      bus(1'b0, O_STAT, 32'h0, 4'hF, r, e);
      n++;
    end while (r[StatusDoneBit] !== 1'b1 && n < 200);
    check_eq({tag, "_done_seen"}, 32'(r[StatusDoneBit]), 32'd1);
  endtask

  initial begin
    logic [31:0] prev_res, d, merged;
    logic [3:0]  be;
    int          len, idx;

    obi_req = '0;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rsp_ctl", 32'({obi_rsp.gnt, obi_rsp.rvalid, obi_rsp.err, obi_rsp.rid}), 32'd0);
    check_eq("rst_rsp_rdata", obi_rsp.rdata, 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    @(negedge clk); rst = 1'b0;

    // 1. reset values
    rd("t1_status", O_STAT, 32'h0, 1'b0);
    rd("t1_result", O_RES, 32'h0, 1'b0);
    rd("t1_len", O_LEN, 32'h0, 1'b0);
    rd("t1_ctrl", O_CTRL, 32'h0, 1'b0);
    check_eq("t1_irq", 32'(irq), 32'd0);

    // decode boundaries and error cases while idle
    rd("unmapped_010", 32'h010, 32'h0, 1'b1);
    rd("below_window", 32'hFFFF_FFFC, 32'h0, 1'b1);
    wr("wr_result", O_RES, 32'hDEAD_BEEF, 4'hF, 1'b1);
    rd("result_kept", O_RES, 32'h0, 1'b0);
    rd("wbuf_past_end", O_WBUF + 32'(4 * DEPTH), 32'h0, 1'b1);
    rd("misaligned", O_WBUF + 32'h2, 32'h0, 1'b1);
    load_w(DEPTH - 1, 32'hA5A5_5A5A);
    rd("wbuf_last", O_WBUF + 32'(4 * (DEPTH - 1)), 32'hA5A5_5A5A, 1'b0);

    // 2. single-word run
    load_w(0, 32'h0102_0304);
    load_f(0, 32'h0101_0101);
    wr("t2_len", O_LEN, 32'd1, 4'hF, 1'b0);
    start_and_count("t2", 1);
    rd("t2_result", O_RES, 32'h0000_000A, 1'b0);
    rd("t2_status", O_STAT, 32'h2, 1'b0);
    check_eq("t2_irq_set", 32'(irq), 32'd1);
    wr("t2_w1c", O_STAT, 32'h2, 4'hF, 1'b0);
    check_eq("t2_irq_clr", 32'(irq), 32'd0);
    rd("t2_status_clr", O_STAT, 32'h0, 1'b0);

    // 3. negative lanes, then full-depth saturating values
    for (int i = 0; i < 2; i++) begin
      load_w(i, 32'hFFFF_FFFF);
      load_f(i, 32'h8080_8080);
    end
    wr("t3_len", O_LEN, 32'd2, 4'hF, 1'b0);
    start_and_count("t3a", 2);
    rd("t3a_result", O_RES, 32'h0000_0400, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      load_w(i, 32'h7F7F_7F7F);
      load_f(i, 32'h7F7F_7F7F);
    end
    wr("t3_len_full", O_LEN, 32'(DEPTH), 4'hF, 1'b0);
    start_and_count("t3b", DEPTH);
    rd("t3b_result", O_RES, 32'(DEPTH * 4 * 16129), 1'b0);

    // 4. illegal lengths
    prev_res = 32'(DEPTH * 4 * 16129);
    wr("t4_clr", O_STAT, 32'h6, 4'hF, 1'b0);
    wr("t4_len0", O_LEN, 32'd0, 4'hF, 1'b0);
    start_and_count("t4a", 0);
    rd("t4a_status", O_STAT, 32'h4, 1'b0);
    rd("t4a_result", O_RES, prev_res, 1'b0);
    wr("t4_clr2", O_STAT, 32'h4, 4'hF, 1'b0);
    rd("t4_status_clr", O_STAT, 32'h0, 1'b0);
    wr("t4_len_big", O_LEN, 32'(DEPTH + 1), 4'hF, 1'b0);
    start_and_count("t4b", 0);
    rd("t4b_status", O_STAT, 32'h4, 1'b0);
    rd("t4b_result", O_RES, prev_res, 1'b0);
    wr("t4_clr3", O_STAT, 32'h4, 4'hF, 1'b0);

    // 5. bus activity during a run
    for (int i = 0; i < DEPTH; i++) begin
      load_w(i, $urandom);
      load_f(i, $urandom);
    end
    wr("t5_len", O_LEN, 32'd8, 4'hF, 1'b0);
    wr("t5_start", O_CTRL, 32'h1, 4'hF, 1'b0);
    wr("t5_fbuf_busy", O_FBUF + 32'd12, 32'h1234_5678, 4'hF, 1'b1);
    rd("t5_unmapped", 32'h3000, 32'h0, 1'b1);
    rd("t5_fbuf_rd_busy", O_FBUF + 32'd12, fmod[3], 1'b0);
    wr("t5_restart", O_CTRL, 32'h1, 4'hF, 1'b0);
    wr("t5_len_busy", O_LEN, 32'd5, 4'hF, 1'b0);
    wait_done("t5");
    rd("t5_result", O_RES, model_dot(8), 1'b0);
    rd("t5_fbuf3", O_FBUF + 32'd12, fmod[3], 1'b0);
    rd("t5_len_after", O_LEN, 32'd5, 1'b0);

    // 6. reset in the middle of a run
    wr("t6_len", O_LEN, 32'd16, 4'hF, 1'b0);
    wr("t6_start", O_CTRL, 32'h1, 4'hF, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_eq("t6_irq", 32'(irq), 32'd0);
    rd("t6_status", O_STAT, 32'h0, 1'b0);
    rd("t6_result", O_RES, 32'h0, 1'b0);
    rd("t6_len", O_LEN, 32'h0, 1'b0);
    load_w(0, 32'hFE03_7F80);
    load_f(0, 32'h0280_7F80);
    wr("t6_len1", O_LEN, 32'd1, 4'hF, 1'b0);
    start_and_count("t6", 1);
    rd("t6_result2", O_RES, model_dot(1), 1'b0);
    check_eq("t6_irq2", 32'(irq), 32'd1);

    // 7. random byte-enable updates and random-length runs
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 4; k++) begin
        idx = $urandom_range(0, DEPTH - 1);
        d   = $urandom;
        be  = 4'($urandom_range(1, 15));
        merged = wmod[idx];
        for (int b = 0; b < 4; b++) if (be[b]) merged[8*b +: 8] = d[8*b +: 8];
        wr("t7_be_wr", O_WBUF + 32'(4 * idx), d, be, 1'b0);
        wmod[idx] = merged;
        rd("t7_be_rd", O_WBUF + 32'(4 * idx), merged, 1'b0);
      end
      len = $urandom_range(1, DEPTH);
      wr("t7_len", O_LEN, 32'(len), 4'hF, 1'b0);
      start_and_count("t7", len);
      rd("t7_result", O_RES, model_dot(len), 1'b0);
      rd("t7_status", O_STAT, 32'h2, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
